// File: rtl/sram_read_arbiter.sv
// ---------------------------------------------------------------------------
// sram_read_arbiter
//
// Shares one SRAM read port between two requesters: the SPI readout path and
// the detector scan path. Grants are combinational and round-robin on ties.
// A per-grant tag (owner + out-of-range flag) follows the SRAM read latency,
// so the shared rdata/rd_err register can be steered to the owner's valid.
//
// Ports
//   clk        in   sole clock, all state on the rising edge
//   res        in   asynchronous active-high reset
//   busy       in   capture in progress; blocks new grants
//   spi_req    in   SPI read request
//   spi_addr   in   SPI read word address [ADDR_W]
//   spi_gnt    out  SPI request accepted this cycle
//   spi_valid  out  rdata belongs to SPI this cycle
//   det_req    in   detector read request
//   det_addr   in   detector read word address [ADDR_W]
//   det_gnt    out  detector request accepted this cycle
//   det_valid  out  rdata belongs to detector this cycle
//   q          in   SRAM read data [DATA_W]
//   rdaddr     out  registered SRAM read address [ADDR_W]
//   rdata      out  registered read data [DATA_W]
//   rd_err     out  delivered read used an address >= LIMIT
// ---------------------------------------------------------------------------
module sram_read_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2,
  parameter int LIMIT  = 640
) (
  input  logic              clk,
  input  logic              res,
  input  logic              busy,
  input  logic              spi_req,
  input  logic [ADDR_W-1:0] spi_addr,
  output logic              spi_gnt,
  output logic              spi_valid,
  input  logic              det_req,
  input  logic [ADDR_W-1:0] det_addr,
  output logic              det_gnt,
  output logic              det_valid,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] rdaddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_err
);

  localparam logic [31:0] LIMIT_U = 32'(LIMIT);

  // last_spi_q = 1 means SPI was granted most recently; reset value 0
  // ("detector last") lets SPI win the first tie.
  logic              last_spi_q, last_spi_d;
  logic [ADDR_W-1:0] rdaddr_q, rdaddr_d;
  logic [RD_LAT-1:0] tag_spi_q, tag_spi_d;
  logic [RD_LAT-1:0] tag_det_q, tag_det_d;
  logic [RD_LAT-1:0] tag_err_q, tag_err_d;
  logic              spi_valid_q, spi_valid_d;
  logic              det_valid_q, det_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_err_q, rd_err_d;

  logic              grant_spi, grant_det, grant_any, grant_err;
  logic [ADDR_W-1:0] grant_addr;

  // Grant decision. Reset is folded in so grants drop the moment res rises,
  // not just at the next edge.
  always_comb begin
    grant_spi = 1'b0;
    grant_det = 1'b0;
    if (!res && !busy) begin
      if (spi_req && det_req) begin
        grant_spi = !last_spi_q;
        grant_det = last_spi_q;
      end else begin
        grant_spi = spi_req;
        grant_det = det_req;
      end
    end
  end

  assign grant_any  = grant_spi | grant_det;
  assign grant_addr = grant_spi ? spi_addr : det_addr;
  assign grant_err  = (32'(grant_addr) >= LIMIT_U);

  // Next-state logic: pointer, read address, tag shift register, and the
  // final capture stage that lands q into rdata one cycle after the read
  // data is valid at the SRAM output.
  always_comb begin
    last_spi_d = last_spi_q;
    if (grant_spi) begin
      last_spi_d = 1'b1;
    end else if (grant_det) begin
      last_spi_d = 1'b0;
    end

    rdaddr_d = rdaddr_q;
    if (grant_any) begin
      rdaddr_d = grant_addr;
    end

    // Stage 0 is loaded with the grant; stage RD_LAT-1 is the cycle in
    // which q for that grant is present.
    tag_spi_d    = '0;
    tag_det_d    = '0;
    tag_err_d    = '0;
    tag_spi_d[0] = grant_spi;
    tag_det_d[0] = grant_det;
    tag_err_d[0] = grant_any & grant_err;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_spi_d[i] = tag_spi_q[i-1];
      tag_det_d[i] = tag_det_q[i-1];
      tag_err_d[i] = tag_err_q[i-1];
    end

    spi_valid_d = tag_spi_q[RD_LAT-1];
    det_valid_d = tag_det_q[RD_LAT-1];
    rdata_d     = rdata_q;
    rd_err_d    = rd_err_q;
    if (spi_valid_d || det_valid_d) begin
      rd_err_d = tag_err_q[RD_LAT-1];
      rdata_d  = tag_err_q[RD_LAT-1] ? '0 : q;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      last_spi_q  <= 1'b0;
      rdaddr_q    <= '0;
      tag_spi_q   <= '0;
      tag_det_q   <= '0;
      tag_err_q   <= '0;
      spi_valid_q <= 1'b0;
      det_valid_q <= 1'b0;
      rdata_q     <= '0;
      rd_err_q    <= 1'b0;
    end else begin
      last_spi_q  <= last_spi_d;
      rdaddr_q    <= rdaddr_d;
      tag_spi_q   <= tag_spi_d;
      tag_det_q   <= tag_det_d;
      tag_err_q   <= tag_err_d;
      spi_valid_q <= spi_valid_d;
      det_valid_q <= det_valid_d;
      rdata_q     <= rdata_d;
      rd_err_q    <= rd_err_d;
    end
  end

  assign spi_gnt   = grant_spi;
  assign det_gnt   = grant_det;
  assign spi_valid = spi_valid_q;
  assign det_valid = det_valid_q;
  assign rdaddr    = rdaddr_q;
  assign rdata     = rdata_q;
  assign rd_err    = rd_err_q;

endmodule

// File: doc/sram_read_arbiter.md
SRAM_READ_ARBITER -- requirements
Module: sram_read_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, SRAM read-address width.
REQ-002 Parameter DATA_W, default 16, SRAM read-data width.
REQ-003 Parameter RD_LAT, default 2, SRAM cycles from rdaddr to valid q (range 1..4).
REQ-004 Parameter LIMIT, default 640, first out-of-range word address.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 res  in  1  reset, asynchronous, active-high.
REQ-007 busy  in  1  capture in progress; blocks new grants.
REQ-008 spi_req  in  1  SPI readout read request.
REQ-009 spi_addr  in  ADDR_W  SPI read word address.
REQ-010 spi_gnt  out  1  SPI request accepted this cycle.
REQ-011 spi_valid  out  1  rdata belongs to SPI this cycle.
REQ-012 det_req  in  1  detector scan read request.
REQ-013 det_addr  in  ADDR_W  detector read word address.
REQ-014 det_gnt  out  1  detector request accepted this cycle.
REQ-015 det_valid  out  1  rdata belongs to detector this cycle.
REQ-016 q  in  DATA_W  SRAM read data.
REQ-017 rdaddr  out  ADDR_W  SRAM read address, registered.
REQ-018 rdata  out  DATA_W  registered read data, shared by both requesters.
REQ-019 rd_err  out  1  accompanies a valid whose address was >= LIMIT.

Function
REQ-020 Requester SHALL hold req and addr stable until sampling its gnt high; gnt high in cycle N means that addr was accepted in cycle N.
REQ-021 spi_gnt/det_gnt SHALL be combinational from req, busy and the priority pointer; never both high; never high while busy=1 or res=1.
REQ-022 Single requester active, busy=0: its gnt SHALL be high in the same cycle.
REQ-023 Both active, busy=0: grant SHALL go to the requester not granted most recently (round-robin pointer updated on every grant).
REQ-024 Accepted requests SHALL be back-to-back capable: one grant per cycle, no idle cycles inserted.
REQ-025 On grant in cycle N, rdaddr SHALL equal the granted addr in cycle N+1 and hold until the next grant.
REQ-026 An owner/err tag pipeline of depth RD_LAT+1 SHALL track each grant; q SHALL be sampled at end of cycle N+RD_LAT into rdata.
REQ-027 Owner's valid SHALL be high for exactly one cycle, N+RD_LAT+1, with rdata valid in that cycle.
REQ-028 Granted addr >= LIMIT: grant still given, rdata=0 and rd_err=1 in the valid cycle; addr < LIMIT gives rd_err=0.
REQ-029 rdata and rd_err SHALL hold their last values when no valid is high.
REQ-030 busy rising SHALL block new grants only; in-flight tags SHALL complete and deliver valids on schedule.
REQ-031 busy falling in cycle M: grants SHALL resume in cycle M, pointer unchanged by the blocked interval.
REQ-032 req deasserted before grant: no grant, no pointer change, no valid.

Reset
REQ-033 res=1 SHALL immediately force spi_gnt=det_gnt=spi_valid=det_valid=rd_err=0, rdaddr=0, rdata=0, tag pipeline empty, pointer = "detector last" (SPI wins first tie).
REQ-034 Reset mid-transfer SHALL discard in-flight reads; no valid SHALL appear after res deasserts until a new grant plus RD_LAT+1 cycles.

Verification
REQ-035 SPI only, spi_addr=0x010, q returns 0xBEEF at N+2 -> spi_gnt at N, rdaddr=0x010 at N+1, spi_valid=1, rdata=0xBEEF at N+3.
REQ-036 Both req held 4 cycles, addrs 0x001/0x002 -> grants SPI,DET,SPI,DET; valids alternate SPI,DET,SPI,DET at N+3..N+6.
REQ-037 det_req held, busy=1 cycles N..N+4 -> no det_gnt N..N+4; det_gnt at N+5; an earlier grant at N-1 still yields det_valid at N+2.
REQ-038 spi_addr=640 and 639 back-to-back -> first valid rdata=0, rd_err=1; second rd_err=0, rdata=q.
REQ-039 Grant at N, res pulsed at N+1 -> no valid at N+3, all outputs 0; post-reset tie grants SPI first.
